uart_cmd_decoder: RTL and testbench

//  Receive-side ASCII command decoder for the smart-watch UART link: consumes bytes popped from the RX FIFO and

---
 rtl/uart_cmd_decoder_pkg.sv | 47 ++++
 rtl/uart_cmd_timeout.sv | 42 ++++
 rtl/uart_cmd_decoder.sv | 148 ++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_decoder_pkg
//  Description : Shared definitions for the UART ASCII command decoder:
//                command codes, ASCII terminators, FSM state encodings and
//                small character/value helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_decoder_pkg;

  // Command codes reported on cmd_code
  localparam logic [2:0] CMD_RUN    = 3'd0;
  localparam logic [2:0] CMD_CLR    = 3'd1;
  localparam logic [2:0] CMD_UP     = 3'd2;
  localparam logic [2:0] CMD_DN     = 3'd3;
  localparam logic [2:0] CMD_MODE   = 3'd4;
  localparam logic [2:0] CMD_REPORT = 3'd5;
  localparam logic [2:0] CMD_SET    = 3'd6;

  // Frame terminators
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Decoder FSM state encodings
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_COLLECT   = 2'd1;
  localparam logic [1:0] ST_WAIT_TERM = 2'd2;
  localparam logic [1:0] ST_DISCARD   = 2'd3;

  // Fold 'a'..'z' onto 'A'..'Z'; every other byte passes through unchanged
  function automatic logic [7:0] to_upper(input logic [7:0] ch);
    if (ch >= 8'h61 && ch <= 8'h7A) begin
      return ch - 8'h20;
    end
    return ch;
  endfunction

  // Two decimal digits to binary, tens*10 as (t<<3)+(t<<1), kept at 7 bits
  function automatic logic [6:0] digits_to_bin(input logic [3:0] tens,
                                               input logic [3:0] ones);
    logic [6:0] t7;
    t7 = {3'b000, tens};
    return (t7 << 3) + (t7 << 1) + {3'b000, ones};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_timeout
//  Description : Inter-byte gap timer. Counts clocks since the last clear,
//                saturating at CYCLES. While enabled, emits a one-cycle
//                expire pulse on the clock where the gap reaches CYCLES.
//                A clear in the same cycle always wins over expiry.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_timeout #(
  parameter int CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int              c_W    = (CYCLES > 1) ? $clog2(CYCLES + 1) : 1;
  localparam logic [c_W-1:0]  c_MAX  = c_W'(CYCLES);
  localparam logic [c_W-1:0]  c_LAST = c_W'(CYCLES - 1);

  logic [c_W-1:0] r_cnt;

  // Gap counter: restart on clear, otherwise count up and hold at CYCLES
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (r_cnt != c_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Fires in the cycle the count is about to reach CYCLES, so the consumer
  // registers it exactly CYCLES clocks after the last clear
  assign expire = en && !clr && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_decoder
//  Description : Receive-side ASCII command decoder. Turns RX FIFO bytes into
//                single-cycle command strobes (R/C/U/D/M/T) or a validated
//                set-time frame "Shhmmss" terminated by CR or LF.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TIMEOUT_MS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       err,
  output logic       busy
);

  localparam int c_TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;

  logic [1:0] r_state;
  logic [2:0] r_cnt;
  logic [3:0] r_dig [0:5];

  logic [7:0] w_ch;
  logic       w_is_digit;
  logic       w_is_term;
  logic       w_expire;
  logic       w_en;
  logic [6:0] w_hour;
  logic [6:0] w_min;
  logic [6:0] w_sec;
  logic       w_range_ok;

  assign w_ch       = to_upper(rx_byte);
  assign w_is_digit = (w_ch >= 8'h30) && (w_ch <= 8'h39);
  assign w_is_term  = (w_ch == ASCII_CR) || (w_ch == ASCII_LF);

  assign w_hour     = digits_to_bin(r_dig[0], r_dig[1]);
  assign w_min      = digits_to_bin(r_dig[2], r_dig[3]);
  assign w_sec      = digits_to_bin(r_dig[4], r_dig[5]);
  assign w_range_ok = (w_hour <= 7'd23) && (w_min <= 7'd59) && (w_sec <= 7'd59);

  assign w_en = (r_state != ST_IDLE);
  assign busy = w_en;

  uart_cmd_timeout #(
    .CYCLES (c_TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (rx_valid),
    .en     (w_en),
    .expire (w_expire)
  );

  // Command FSM: decodes single-char commands and collects set-time frames;
  // a received byte always takes priority over a coincident timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 3'd0;
      r_dig     <= '{default: 4'd0};
      cmd_valid <= 1'b0;
      cmd_code  <= 3'd0;
      set_hour  <= 5'd0;
      set_min   <= 6'd0;
      set_sec   <= 6'd0;
      err       <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      err       <= 1'b0;
      if (rx_valid) begin
        case (r_state)
          ST_IDLE: begin
            case (w_ch)
              8'h52: begin cmd_valid <= 1'b1; cmd_code <= CMD_RUN;    end // R
              8'h43: begin cmd_valid <= 1'b1; cmd_code <= CMD_CLR;    end // C
              8'h55: begin cmd_valid <= 1'b1; cmd_code <= CMD_UP;     end // U
              8'h44: begin cmd_valid <= 1'b1; cmd_code <= CMD_DN;     end // D
              8'h4D: begin cmd_valid <= 1'b1; cmd_code <= CMD_MODE;   end // M
              8'h54: begin cmd_valid <= 1'b1; cmd_code <= CMD_REPORT; end // T
              8'h53: begin                                                // S
                r_state <= ST_COLLECT;
                r_cnt   <= 3'd0;
              end
              ASCII_CR, ASCII_LF: ;
              default: err <= 1'b1;
            endcase
          end
          ST_COLLECT: begin
            if (w_is_digit) begin
              r_dig[r_cnt] <= w_ch[3:0];
              r_cnt        <= r_cnt + 3'd1;
              if (r_cnt == 3'd5) begin
                r_state <= ST_WAIT_TERM;
              end
            end else if (w_is_term) begin
              err     <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              err     <= 1'b1;
              r_state <= ST_DISCARD;
            end
          end
          ST_WAIT_TERM: begin
            if (w_is_term) begin
              r_state <= ST_IDLE;
              if (w_range_ok) begin
                set_hour  <= w_hour[4:0];
                set_min   <= w_min[5:0];
                set_sec   <= w_sec[5:0];
                cmd_code  <= CMD_SET;
                cmd_valid <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end else begin
              err     <= 1'b1;
              r_state <= ST_DISCARD;
            end
          end
          default: begin // ST_DISCARD: silently drop until a terminator
            if (w_is_term) begin
              r_state <= ST_IDLE;
            end
          end
        endcase
      end else if (w_expire) begin
        if (r_state != ST_DISCARD) begin
          err <= 1'b1;
        end
        r_state <= ST_IDLE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_cmd_decoder
//  Description : Scoreboard bench for uart_cmd_decoder. Expected command and
//                error strobes are queued as bytes are driven and checked
//                against DUT output as it appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_decoder;

  localparam int K_NONE = 0;
  localparam int K_CMD  = 1;
  localparam int K_ERR  = 2;

  localparam int E_RUN = 0, E_CLR = 1, E_UP = 2, E_DN = 3, E_MODE = 4, E_REPORT = 5, E_SET = 6;
  localparam int TO_CYC = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic [5:0] set_sec;
  logic       err;
  logic       busy;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int kind;
    int at;
    int code;
    int h;
    int m;
    int s;
  } exp_t;

  exp_t sb[$];

  uart_cmd_decoder #(
    .CLK_HZ     (1000),
    .TIMEOUT_MS (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .set_hour  (set_hour),
    .set_min   (set_min),
    .set_sec   (set_sec),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input int at, input int code,
                      input int h, input int m, input int s);
    exp_t e;
    e.kind = kind; e.at = at; e.code = code; e.h = h; e.m = m; e.s = s;
    sb.push_back(e);
  endtask

  // Drive one byte for one cycle (called at a negedge), queueing its expected result
  task automatic send(input logic [7:0] b, input int kind, input int code,
                      input int h, input int m, input int s);
    rx_byte  = b;
    rx_valid = 1'b1;
    if (kind != K_NONE) push(kind, cyc + 1, code, h, m, s);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string str);
    for (int i = 0; i < str.len(); i++) begin
      send(str[i], K_NONE, 0, 0, 0, 0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Output monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && (cmd_valid || err)) begin
      check("strobe_exclusive", int'(cmd_valid && err), 0);
      if (sb.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e = sb.pop_front();
        check("strobe_kind", cmd_valid ? K_CMD : K_ERR, e.kind);
        check("strobe_cycle", cyc, e.at);
        if (e.kind == K_CMD) begin
          check("cmd_code", int'(cmd_code), e.code);
          if (e.code == E_SET) begin
            check("set_hour", int'(set_hour), e.h);
            check("set_min", int'(set_min), e.m);
            check("set_sec", int'(set_sec), e.s);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin : stim
    int last;
    idle(3);
    check("rst_cmd_valid", int'(cmd_valid), 0);
    check("rst_cmd_code", int'(cmd_code), 0);
    check("rst_set_hour", int'(set_hour), 0);
    check("rst_set_min", int'(set_min), 0);
    check("rst_set_sec", int'(set_sec), 0);
    check("rst_err", int'(err), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    idle(2);

    // Single-character commands, mixed case, and ignored terminators
    send("r", K_CMD, E_RUN, 0, 0, 0);
    send("T", K_CMD, E_REPORT, 0, 0, 0);
    send(8'h0D, K_NONE, 0, 0, 0, 0);
    send(8'h0A, K_NONE, 0, 0, 0, 0);
    send("u", K_CMD, E_UP, 0, 0, 0);
    send("d", K_CMD, E_DN, 0, 0, 0);
    send("M", K_CMD, E_MODE, 0, 0, 0);
    send("c", K_CMD, E_CLR, 0, 0, 0);
    send("X", K_ERR, 0, 0, 0, 0);
    idle(2);
    check("busy_idle", int'(busy), 0);

    // Maximum valid set-time
    send_str("S235959");
    check("busy_collect", int'(busy), 1);
    send(8'h0D, K_CMD, E_SET, 23, 59, 59);
    idle(2);
    check("busy_after_set", int'(busy), 0);

    // Hour out of range: error, previous time retained
    send_str("S240000");
    send(8'h0A, K_ERR, 0, 0, 0, 0);
    idle(2);
    check("keep_hour", int'(set_hour), 23);
    check("keep_min", int'(set_min), 59);
    check("keep_sec", int'(set_sec), 59);

    // Bad character mid-frame: single error, discard to LF, then normal decode
    send_str("S12");
    send("a", K_ERR, 0, 0, 0, 0);
    send_str("4");
    check("busy_discard", int'(busy), 1);
    send(8'h0A, K_NONE, 0, 0, 0, 0);
    send("R", K_CMD, E_RUN, 0, 0, 0);
    idle(2);

    // Seventh digit, early terminator, minimum value, minute/second range edges
    send_str("S123456");
    send("7", K_ERR, 0, 0, 0, 0);
    send(8'h0D, K_NONE, 0, 0, 0, 0);
    send_str("S075");
    send(8'h0D, K_ERR, 0, 0, 0, 0);
    send("D", K_CMD, E_DN, 0, 0, 0);
    send_str("S000000");
    send(8'h0D, K_CMD, E_SET, 0, 0, 0);
    send_str("S235960");
    send(8'h0D, K_ERR, 0, 0, 0, 0);
    send_str("S236059");
    send(8'h0A, K_ERR, 0, 0, 0, 0);
    send_str("S125930");
    send(8'h0A, K_CMD, E_SET, 12, 59, 30);
    idle(2);

    // Inter-byte timeout inside a frame
    send_str("S1");
    last = cyc + 1;
    send("2", K_NONE, 0, 0, 0, 0);
    push(K_ERR, last + TO_CYC, 0, 0, 0, 0);
    idle(5);
    check("busy_before_timeout", int'(busy), 1);
    idle(10);
    check("busy_after_timeout", int'(busy), 0);

    // Timeout while discarding is silent
    send_str("S");
    send("X", K_ERR, 0, 0, 0, 0);
    idle(TO_CYC + 5);
    check("busy_after_discard_timeout", int'(busy), 0);

    // Reset mid-frame drops the partial frame
    send_str("S1234");
    rst = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_cmd_valid", int'(cmd_valid), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_set_hour", int'(set_hour), 0);
    check("midrst_cmd_code", int'(cmd_code), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    send("C", K_CMD, E_CLR, 0, 0, 0);
    idle(4);

    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
